// File: rtl/my_elements_pkg.sv
// Shared element types for the 16-bit demultiplexer register slice.
package my_elements_pkg;

  // Routed data word.
  typedef shortint word_t;

  // Occupancy of a one-word holding slot.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  // Ready-to-load rule shared by every slot: free, or emptying this edge.
  function automatic logic slot_can_load(input slot_state_t st, input logic out_ready);
    return (st == EMPTY) || out_ready;
  endfunction

endpackage

// File: rtl/my_dmux16_reg_if.sv
// Handshake bundle for my_dmux16_reg: one input stream, two output channels
// with per-channel transfer counters.
interface my_dmux16_reg_if #(
  parameter int unsigned CNT_W = 8
) ();
  import my_elements_pkg::*;

  word_t            in;
  logic             sel;
  logic             in_valid;
  logic             in_ready;

  word_t            out0;
  word_t            out1;
  logic             out_valid0;
  logic             out_valid1;
  logic             out_ready0;
  logic             out_ready1;

  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Producer/consumer side (testbench or surrounding logic).
  modport master (
    output in, sel, in_valid, out_ready0, out_ready1,
    input  in_ready, out0, out1, out_valid0, out_valid1, cnt0, cnt1
  );

  // Demultiplexer side.
  modport slave (
    input  in, sel, in_valid, out_ready0, out_ready1,
    output in_ready, out0, out1, out_valid0, out_valid1, cnt0, cnt1
  );

endinterface

// File: rtl/my_dmux16_slot.sv
// One-word holding slot with a wrapping count of completed output transfers.
// A load on the same edge as a drain replaces the word and keeps the slot FULL.
module my_dmux16_slot
  import my_elements_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  word_t            din,
  input  logic             out_ready,
  output logic             load_ready,
  output word_t            dout,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);

  slot_state_t      state_q;
  slot_state_t      state_d;
  word_t            data_q;
  logic [CNT_W-1:0] cnt_q;
  logic             drain;

  // Slot occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next occupancy and handshake outputs.
  always_comb begin
    state_d    = state_q;
    drain      = (state_q == FULL) && out_ready;
    load_ready = slot_can_load(state_q, out_ready);
    valid      = (state_q == FULL);
    case (state_q)
      EMPTY: begin
        if (load) begin
          state_d = FULL;
        end
      end
      FULL: begin
        if (drain && !load) begin
          state_d = EMPTY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Data word: kept after draining so the output shows the last loaded value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= din;
    end
  end

  // Completed output transfers, wrapping at the counter width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (drain) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign dout = data_q;
  assign cnt  = cnt_q;

endmodule

// File: rtl/my_dmux16_reg.sv
// 1-to-2 registered demultiplexer: sel steers each accepted word into the
// holding slot of channel 0 or channel 1.
module my_dmux16_reg
  import my_elements_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  my_dmux16_reg_if.slave    bus
);

  logic ready0;
  logic ready1;
  logic in_rdy;
  logic accept;
  logic load0;
  logic load1;

  // Ready follows the selected slot only; loads go only to the selected slot.
  always_comb begin
    in_rdy = bus.sel ? ready1 : ready0;
    accept = bus.in_valid && in_rdy;
    load0  = accept && !bus.sel;
    load1  = accept &&  bus.sel;
  end

  assign bus.in_ready = in_rdy;

  my_dmux16_slot #(
    .CNT_W (CNT_W)
  ) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load0),
    .din        (bus.in),
    .out_ready  (bus.out_ready0),
    .load_ready (ready0),
    .dout       (bus.out0),
    .valid      (bus.out_valid0),
    .cnt        (bus.cnt0)
  );

  my_dmux16_slot #(
    .CNT_W (CNT_W)
  ) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load1),
    .din        (bus.in),
    .out_ready  (bus.out_ready1),
    .load_ready (ready1),
    .dout       (bus.out1),
    .valid      (bus.out_valid1),
    .cnt        (bus.cnt1)
  );

endmodule

// File: tb/tb_my_dmux16_reg.sv
// Self-checking bench for my_dmux16_reg: directed scenarios with literal
// expectations plus a queue-based reference model compared every cycle.
module tb_my_dmux16_reg;
  import my_elements_pkg::*;

  localparam int unsigned CNT_W = 8;

  logic clk;
  logic rst_n;

  int total = 0;
  int bad   = 0;

  my_dmux16_reg_if #(.CNT_W(CNT_W)) bus ();

  my_dmux16_reg #(
    .CNT_W (CNT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: each channel is a FIFO of words waiting to be taken,
  // plus the last word ever routed to it and a plain transfer tally.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] mlast0 = 16'h0;
  logic [15:0] mlast1 = 16'h0;
  int          mcnt0  = 0;
  int          mcnt1  = 0;
  logic        macc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      mlast0 = 16'h0;
      mlast1 = 16'h0;
      mcnt0  = 0;
      mcnt1  = 0;
    end else begin
      macc = bus.in_valid &&
             (bus.sel ? (q1.size() == 0 || bus.out_ready1)
                      : (q0.size() == 0 || bus.out_ready0));
      if (q0.size() != 0 && bus.out_ready0) begin
        void'(q0.pop_front());
        mcnt0++;
      end
      if (q1.size() != 0 && bus.out_ready1) begin
        void'(q1.pop_front());
        mcnt1++;
      end
      if (macc) begin
        if (bus.sel) begin
          q1.push_back(16'(bus.in));
          mlast1 = 16'(bus.in);
        end else begin
          q0.push_back(16'(bus.in));
          mlast0 = 16'(bus.in);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic exp_rdy;
    exp_rdy = bus.sel ? (q1.size() == 0 || bus.out_ready1)
                      : (q0.size() == 0 || bus.out_ready0);
    check("m_valid0", 16'(bus.out_valid0), 16'(q0.size() != 0));
    check("m_valid1", 16'(bus.out_valid1), 16'(q1.size() != 0));
    check("m_out0",   16'(bus.out0), mlast0);
    check("m_out1",   16'(bus.out1), mlast1);
    check("m_cnt0",   16'(bus.cnt0), 16'(mcnt0 % (1 << CNT_W)));
    check("m_cnt1",   16'(bus.cnt1), 16'(mcnt1 % (1 << CNT_W)));
    check("m_ready",  16'(bus.in_ready), 16'(exp_rdy));
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d,
                       input logic r0, input logic r1);
    bus.in_valid   = v;
    bus.sel        = s;
    bus.in         = word_t'(d);
    bus.out_ready0 = r0;
    bus.out_ready1 = r1;
  endtask

  // Compare mid-cycle, then advance to just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare_model();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    #3;
    check("rst_valid0", 16'(bus.out_valid0), 16'h0);
    check("rst_valid1", 16'(bus.out_valid1), 16'h0);
    check("rst_out0",   16'(bus.out0), 16'h0);
    check("rst_cnt1",   16'(bus.cnt1), 16'h0);
    check("rst_ready",  16'(bus.in_ready), 16'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single word to channel 0, then drained.
    drive(1'b1, 1'b0, 16'h1234, 1'b0, 1'b0);
    tick();
    check("d1_out0",   16'(bus.out0), 16'h1234);
    check("d1_valid0", 16'(bus.out_valid0), 16'h1);
    check("d1_valid1", 16'(bus.out_valid1), 16'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    check("d1_cnt0",   16'(bus.cnt0), 16'h1);
    check("d1_empty0", 16'(bus.out_valid0), 16'h0);
    check("d1_hold0",  16'(bus.out0), 16'h1234);
    check("d1_cnt1",   16'(bus.cnt1), 16'h0);

    // Back-pressure on channel 1.
    drive(1'b1, 1'b1, 16'hAAAA, 1'b0, 1'b0);
    tick();
    check("d2_out1a", 16'(bus.out1), 16'hAAAA);
    drive(1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b0);
    #1;
    check("d2_block", 16'(bus.in_ready), 16'h0);
    tick();
    check("d2_stable", 16'(bus.out1), 16'hAAAA);
    drive(1'b1, 1'b1, 16'hBBBB, 1'b0, 1'b1);
    #1;
    check("d2_open", 16'(bus.in_ready), 16'h1);
    tick();
    check("d2_out1b",   16'(bus.out1), 16'hBBBB);
    check("d2_valid1",  16'(bus.out_valid1), 16'h1);
    check("d2_cnt1",    16'(bus.cnt1), 16'h1);

    // Channel 1 stalled does not block channel 0.
    drive(1'b1, 1'b0, 16'h5555, 1'b0, 1'b0);
    #1;
    check("d3_ready", 16'(bus.in_ready), 16'h1);
    tick();
    check("d3_out0", 16'(bus.out0), 16'h5555);
    check("d3_out1", 16'(bus.out1), 16'hBBBB);

    // Both FULL, then asynchronous reset between edges.
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid0", 16'(bus.out_valid0), 16'h0);
    check("ar_valid1", 16'(bus.out_valid1), 16'h0);
    check("ar_out0",   16'(bus.out0), 16'h0);
    check("ar_out1",   16'(bus.out1), 16'h0);
    check("ar_cnt0",   16'(bus.cnt0), 16'h0);
    check("ar_cnt1",   16'(bus.cnt1), 16'h0);
    check("ar_ready",  16'(bus.in_ready), 16'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Counter wrap: 256 drains on channel 0.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b0, 16'(i), 1'b1, 1'b0);
      tick();
    end
    check("w_cnt255", 16'(bus.cnt0), 16'h00FF);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    check("w_cnt0", 16'(bus.cnt0), 16'h0);
    check("w_cnt1", 16'(bus.cnt1), 16'h0);
    check("w_out0", 16'(bus.out0), 16'h00FF);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/my_dmux16_reg.md
MY_DMUX16_REG -- requirements
Module: my_dmux16_reg

Interface
REQ-001 Parameter: CNT_W, default 8, width of each per-channel transfer counter.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in  input  16 (shortint)  data word to be routed.
REQ-006 sel  input  1  destination select: 0 -> channel 0, 1 -> channel 1.
REQ-007 in_valid  input  1  in/sel carry a word this cycle.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 out0, out1  output  16 each  channel data word.
REQ-010 out_valid0, out_valid1  output  1 each  channel holds a word.
REQ-011 out_ready0, out_ready1  input  1 each  channel consumer takes the word.
REQ-012 cnt0, cnt1  output  CNT_W each  completed output transfers per channel.

Function
REQ-013 Input transfer SHALL occur exactly when in_valid and in_ready are both 1 at a rising edge.
REQ-014 Output transfer on channel k SHALL occur exactly when out_validk and out_readyk are both 1 at a rising edge.
REQ-015 Each channel SHALL have a one-word holding slot with states EMPTY and FULL; out_validk is 1 iff the slot is FULL.
REQ-016 in_ready SHALL be combinational: 1 iff slot[sel] is EMPTY, or slot[sel] is FULL and out_ready[sel] is 1; it depends on sel but not on in_valid.
REQ-017 Latency: a word accepted at edge N SHALL appear on out[sel] with out_valid[sel]=1 from edge N onward (visible the cycle after acceptance); no combinational in->out path.
REQ-018 Slot transitions: EMPTY + load -> FULL; FULL + drain, no load -> EMPTY; FULL + drain + load (same edge) -> FULL holding the new word; otherwise hold.
REQ-019 The unselected channel's slot, data and counter SHALL be unaffected by an input transfer.
REQ-020 While out_validk=1 and out_readyk=0, outk SHALL remain stable.
REQ-021 When a slot is EMPTY, outk SHALL hold the last word loaded into it (0 if none since reset).
REQ-022 sel SHALL be ignored when in_valid is 0; no word is ever dropped or duplicated.
REQ-023 cntk SHALL increment by 1 on each channel-k output transfer and wrap from 2^CNT_W-1 to 0.
REQ-024 Both channels MAY drain on the same edge and an input transfer MAY coincide; all SHALL take effect independently.

Reset
REQ-025 While rst_n=0: both slots EMPTY, out_valid0/1=0, out0/out1=0, cnt0/cnt1=0; in_ready then reads 1.
REQ-026 Reset assertion mid-operation SHALL discard held words immediately (asynchronous), without waiting for clk.
REQ-027 Deassertion SHALL take effect at the next rising edge; no transfer occurs on the edge coincident with rst_n low.

Structure
REQ-028 Shared package my_elements_pkg SHALL hold typedef word_t (16-bit shortint) and enum slot_state_t {EMPTY, FULL}.
REQ-029 One sub-module my_dmux16_slot (one-word slot + CNT_W counter, load/drain/valid/ready) SHALL be instantiated twice.
REQ-030 Top level SHALL contain only the sel-steered load enables and the in_ready mux.

Verification
REQ-031 Reset, then in=16'h1234, sel=0, in_valid=1 one cycle, out_ready0=1 -> out0=16'h1234, out_valid0=1 next cycle, cnt0=1 after drain; channel 1 untouched.
REQ-032 out_ready1=0, push 16'hAAAA sel=1 then 16'hBBBB sel=1 -> second word sees in_ready=0, out1 stays 16'hAAAA; raise out_ready1 -> 16'hBBBB accepted on the drain edge.
REQ-033 Slot 1 FULL with out_ready1=0, push 16'h5555 sel=0 -> in_ready=1, out0=16'h5555, out1 unchanged.
REQ-034 CNT_W=8, 256 transfers on channel 0 -> cnt0 returns to 0; cnt1 stays 0.
REQ-035 Both slots FULL, assert rst_n=0 between edges -> out_valid0/1, out0/1, cnt0/1 go to 0 immediately; in_ready=1.
REQ-036 Random valid/ready/sel for 10k cycles -> per-channel output order and contents match a reference queue model; cntk equals transfer count mod 2^CNT_W.
